// File: rtl/arf_stack_sequencer_pkg.sv
// Shared encodings for the stack sequencer: op codes, register-file selects
// and the controller state enum.
package arf_stack_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_CALL = 2'b00,
        OP_RET  = 2'b01,
        OP_PUSH = 2'b10,
        OP_POP  = 2'b11
    } op_e;

    localparam logic [1:0] FUN_DEC  = 2'b00;
    localparam logic [1:0] FUN_INC  = 2'b01;
    localparam logic [1:0] FUN_LOAD = 2'b10;
    localparam logic [1:0] FUN_CLR  = 2'b11;

    localparam logic [2:0] REG_NONE = 3'b000;
    localparam logic [2:0] REG_PC   = 3'b100;
    localparam logic [2:0] REG_SP   = 3'b010;
    localparam logic [2:0] REG_AR   = 3'b001;

    localparam logic [1:0] OUT_PC = 2'b00;
    localparam logic [1:0] OUT_SP = 2'b01;
    localparam logic [1:0] OUT_AR = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WH,
        S_WL,
        S_INC,
        S_RL,
        S_RH,
        S_LD,
        S_DONE
    } state_e;

endpackage

// File: rtl/arf_stack_sequencer.sv
// Multi-cycle PUSH/POP/CALL/RET sequencer driving the address register file
// and the byte-wide data memory. All outputs are registered from next state.
module arf_stack_sequencer
    import arf_stack_sequencer_pkg::*;
#(
    parameter logic [15:0] SP_MIN = 16'h0002,
    parameter logic [15:0] SP_MAX = 16'hFFFD
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [15:0] PushData,
    input  logic [15:0] Target,
    input  logic [15:0] ARF_OutC,
    input  logic [15:0] ARF_OutD,
    input  logic [7:0]  MemData,
    output logic [2:0]  ARF_RegSel,
    output logic [1:0]  ARF_FunSel,
    output logic [1:0]  ARF_OutCSel,
    output logic [1:0]  ARF_OutDSel,
    output logic [15:0] LoadData,
    output logic        Mem_CS,
    output logic        Mem_WR,
    output logic [7:0]  Mem_WrData,
    output logic [15:0] PopData,
    output logic        Busy,
    output logic        Done,
    output logic        Fault
);

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [15:0] held_q, held_d;
    logic [7:0]  tmp_lo_q, tmp_lo_d;
    logic [2:0]  regsel_q, regsel_d;
    logic [1:0]  funsel_q, funsel_d;
    logic        cs_q, cs_d;
    logic        wr_q, wr_d;
    logic [7:0]  wrdata_q, wrdata_d;
    logic [15:0] popdata_q, popdata_d;
    logic [15:0] loaddata_q, loaddata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;
    logic        start_illegal;

    // Pushes move SP down by two and pops move it up by two; reject ops that would wrap.
    always_comb begin
        start_illegal = 1'b0;
        if ((op_e'(Op) == OP_PUSH) || (op_e'(Op) == OP_CALL))
            start_illegal = (ARF_OutD < SP_MIN);
        else
            start_illegal = (ARF_OutD > SP_MAX);
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        held_d     = held_q;
        tmp_lo_d   = tmp_lo_q;
        popdata_d  = popdata_q;
        loaddata_d = loaddata_q;
        fault_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    if (start_illegal) begin
                        fault_d = 1'b1;
                    end else begin
                        op_d   = op_e'(Op);
                        held_d = (op_e'(Op) == OP_PUSH) ? PushData : ARF_OutC;
                        if (op_e'(Op) == OP_CALL)
                            loaddata_d = Target;
                        if ((op_e'(Op) == OP_PUSH) || (op_e'(Op) == OP_CALL))
                            state_d = S_WH;
                        else
                            state_d = S_INC;
                    end
                end
            end
            S_WH:  state_d = S_WL;
            S_WL:  state_d = (op_q == OP_CALL) ? S_LD : S_DONE;
            S_INC: state_d = S_RL;
            S_RL: begin
                tmp_lo_d = MemData;
                state_d  = S_RH;
            end
            S_RH: begin
                popdata_d = {MemData, tmp_lo_q};
                if (op_q == OP_RET) begin
                    loaddata_d = {MemData, tmp_lo_q};
                    state_d    = S_LD;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_LD:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are a function of the state being entered, so they line up with it.
    always_comb begin
        regsel_d = REG_NONE;
        funsel_d = FUN_DEC;
        cs_d     = 1'b0;
        wr_d     = 1'b0;
        wrdata_d = 8'h00;
        done_d   = 1'b0;
        busy_d   = (state_d != S_IDLE);

        case (state_d)
            S_WH: begin
                cs_d     = 1'b1;
                wr_d     = 1'b1;
                wrdata_d = held_d[15:8];
                regsel_d = REG_SP;
                funsel_d = FUN_DEC;
            end
            S_WL: begin
                cs_d     = 1'b1;
                wr_d     = 1'b1;
                wrdata_d = held_d[7:0];
                regsel_d = REG_SP;
                funsel_d = FUN_DEC;
            end
            S_INC: begin
                regsel_d = REG_SP;
                funsel_d = FUN_INC;
            end
            S_RL: begin
                cs_d     = 1'b1;
                regsel_d = REG_SP;
                funsel_d = FUN_INC;
            end
            S_RH: cs_d = 1'b1;
            S_LD: begin
                regsel_d = REG_PC;
                funsel_d = FUN_LOAD;
            end
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= S_IDLE;
            op_q       <= OP_CALL;
            regsel_q   <= REG_NONE;
            funsel_q   <= FUN_DEC;
            cs_q       <= 1'b0;
            wr_q       <= 1'b0;
            wrdata_q   <= 8'h00;
            popdata_q  <= 16'h0000;
            loaddata_q <= 16'h0000;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            regsel_q   <= regsel_d;
            funsel_q   <= funsel_d;
            cs_q       <= cs_d;
            wr_q       <= wr_d;
            wrdata_q   <= wrdata_d;
            popdata_q  <= popdata_d;
            loaddata_q <= loaddata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fault_q    <= fault_d;
        end
    end

    // Holding registers are only consumed after being written in the same op.
    always_ff @(posedge Clock) begin
        held_q   <= held_d;
        tmp_lo_q <= tmp_lo_d;
    end

    assign ARF_RegSel  = regsel_q;
    assign ARF_FunSel  = funsel_q;
    assign ARF_OutCSel = OUT_PC;
    assign ARF_OutDSel = OUT_SP;
    assign LoadData    = loaddata_q;
    assign Mem_CS      = cs_q;
    assign Mem_WR      = wr_q;
    assign Mem_WrData  = wrdata_q;
    assign PopData     = popdata_q;
    assign Busy        = busy_q;
    assign Done        = done_q;
    assign Fault       = fault_q;

endmodule

// File: tb/tb_arf_stack_sequencer.sv
// Bench for arf_stack_sequencer: register-file/memory environment plus a
// word-level stack reference model, directed cases and randomized ops.
module tb_arf_stack_sequencer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start;
    logic [1:0]  Op;
    logic [15:0] PushData;
    logic [15:0] Target;
    logic [15:0] ARF_OutC;
    logic [15:0] ARF_OutD;
    logic [7:0]  MemData;
    logic [2:0]  ARF_RegSel;
    logic [1:0]  ARF_FunSel;
    logic [1:0]  ARF_OutCSel;
    logic [1:0]  ARF_OutDSel;
    logic [15:0] LoadData;
    logic        Mem_CS;
    logic        Mem_WR;
    logic [7:0]  Mem_WrData;
    logic [15:0] PopData;
    logic        Busy;
    logic        Done;
    logic        Fault;

    always #5 Clock = ~Clock;

    arf_stack_sequencer dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Start      (Start),
        .Op         (Op),
        .PushData   (PushData),
        .Target     (Target),
        .ARF_OutC   (ARF_OutC),
        .ARF_OutD   (ARF_OutD),
        .MemData    (MemData),
        .ARF_RegSel (ARF_RegSel),
        .ARF_FunSel (ARF_FunSel),
        .ARF_OutCSel(ARF_OutCSel),
        .ARF_OutDSel(ARF_OutDSel),
        .LoadData   (LoadData),
        .Mem_CS     (Mem_CS),
        .Mem_WR     (Mem_WR),
        .Mem_WrData (Mem_WrData),
        .PopData    (PopData),
        .Busy       (Busy),
        .Done       (Done),
        .Fault      (Fault)
    );

    // Environment: PC/SP registers and a 64 KiB byte memory addressed by SP.
    logic [15:0] pc_r = 16'h0000;
    logic [15:0] sp_r = 16'h0000;
    logic [7:0]  mem [0:65535];
    logic        init_done = 1'b0;
    logic        pre_en;
    logic [15:0] pre_sp;
    logic [15:0] pre_pc;
    int          cs_cnt = 0;

    function automatic logic [7:0] pattern(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
    endfunction

    function automatic logic [15:0] apply_fun(input logic [15:0] v, input logic [1:0] f,
                                              input logic [15:0] d);
        case (f)
            2'b00:   return v - 16'd1;
            2'b01:   return v + 16'd1;
            2'b10:   return d;
            default: return 16'h0000;
        endcase
    endfunction

    always @(posedge Clock) begin
        if (!init_done) begin
            for (int i = 0; i < 65536; i++) mem[i] <= pattern(16'(i));
            init_done <= 1'b1;
        end else if (pre_en) begin
            sp_r <= pre_sp;
            pc_r <= pre_pc;
        end else begin
            if (ARF_RegSel[2]) pc_r <= apply_fun(pc_r, ARF_FunSel, LoadData);
            if (ARF_RegSel[1]) sp_r <= apply_fun(sp_r, ARF_FunSel, LoadData);
            if (Mem_CS && Mem_WR) mem[sp_r] <= Mem_WrData;
        end
        if (Mem_CS) cs_cnt <= cs_cnt + 1;
    end

    assign ARF_OutC = pc_r;
    assign ARF_OutD = sp_r;
    assign MemData  = mem[sp_r];

    // Reference model: a word stack over a sparse byte map.
    logic [15:0] ref_sp, ref_pc, ref_popv;
    logic [7:0]  ref_mem [logic [15:0]];

    function automatic logic [7:0] ref_rd(input logic [15:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return pattern(a);
    endfunction

    task automatic ref_push(input logic [15:0] w);
        ref_mem[ref_sp]          = w[15:8];
        ref_mem[ref_sp - 16'd1]  = w[7:0];
        ref_sp                   = ref_sp - 16'd2;
    endtask

    task automatic ref_pop(output logic [15:0] w);
        w      = {ref_rd(ref_sp + 16'd2), ref_rd(ref_sp + 16'd1)};
        ref_sp = ref_sp + 16'd2;
    endtask

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_regs(input logic [15:0] sp, input logic [15:0] pc);
        @(negedge Clock);
        pre_en = 1'b1;
        pre_sp = sp;
        pre_pc = pc;
        @(negedge Clock);
        pre_en = 1'b0;
        ref_sp = sp;
        ref_pc = pc;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [15:0] pd, input logic [15:0] tg);
        logic [15:0] sp0, w, a;
        logic        legal;
        int          lat, cyc, cs0, exp_cs;
        sp0    = ref_sp;
        legal  = (op[0] == 1'b0) ? (sp0 >= 16'h0002) : (sp0 <= 16'hFFFD);
        lat    = 1;
        exp_cs = 0;
        if (legal) begin
            case (op)
                2'b10: begin ref_push(pd); lat = 3; end
                2'b00: begin ref_push(ref_pc); ref_pc = tg; lat = 4; end
                2'b11: begin ref_pop(w); ref_popv = w; lat = 4; end
                default: begin ref_pop(w); ref_popv = w; ref_pc = w; lat = 5; end
            endcase
            exp_cs = 2;
        end
        cs0 = cs_cnt;
        @(negedge Clock);
        Start = 1'b1; Op = op; PushData = pd; Target = tg;
        @(posedge Clock); #1;
        Start = 1'b0; PushData = 16'($urandom); Target = 16'($urandom);
        cyc = 1;
        while (!Done && !Fault && cyc < 12) begin
            check("busy_mid", Busy, 1);
            @(posedge Clock); #1;
            cyc++;
        end
        check("done", Done, legal);
        check("fault", Fault, !legal);
        check("latency", cyc, lat);
        check("busy_end", Busy, legal);
        check("outsel", {ARF_OutCSel, ARF_OutDSel}, 4'b0001);
        @(posedge Clock); #1;
        check("pulse_end", {Done, Fault, Busy}, 0);
        check("sp", sp_r, ref_sp);
        check("pc", pc_r, ref_pc);
        check("popdata", PopData, ref_popv);
        check("cs_count", cs_cnt - cs0, exp_cs);
        for (int k = -1; k <= 2; k++) begin
            a = sp0 + 16'(k);
            check("mem", mem[a], ref_rd(a));
        end
    endtask

    logic [15:0] bnd [8] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003,
                              16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF};
    logic [0:6]  bb_busy = 7'b1110111;
    logic [0:6]  bb_done = 7'b0010001;

    initial begin
        Reset = 1'b0; Start = 1'b0; Op = 2'b00; PushData = 16'h0; Target = 16'h0;
        pre_en = 1'b0; pre_sp = 16'h0; pre_pc = 16'h0;
        ref_sp = 16'h0; ref_pc = 16'h0; ref_popv = 16'h0;
        repeat (3) @(posedge Clock);
        #1;
        check("rst_out", {ARF_RegSel, ARF_FunSel, Mem_CS, Mem_WR, Mem_WrData, Busy, Done, Fault}, 0);
        check("rst_data", {PopData, LoadData}, 0);
        @(negedge Clock);
        Reset = 1'b1;

        // PUSH 0xBEEF at SP 0x0100
        set_regs(16'h0100, 16'h0000);
        run_op(2'b10, 16'hBEEF, 16'h0);
        check("push_sp", sp_r, 16'h00FE);
        check("push_hi", mem[16'h0100], 8'hBE);
        check("push_lo", mem[16'h00FF], 8'hEF);

        // CALL then RET
        set_regs(16'h0200, 16'h1234);
        run_op(2'b00, 16'h0, 16'h4000);
        check("call_pc", pc_r, 16'h4000);
        check("call_sp", sp_r, 16'h01FE);
        check("call_mem", {mem[16'h0200], mem[16'h01FF]}, 16'h1234);
        run_op(2'b01, 16'h0, 16'h0);
        check("ret_pc", pc_r, 16'h1234);
        check("ret_sp", sp_r, 16'h0200);
        check("ret_pop", PopData, 16'h1234);

        // Limit faults and legal extremes
        set_regs(16'h0001, 16'h0010); run_op(2'b10, 16'h1357, 16'h0);
        check("fault_push_sp", sp_r, 16'h0001);
        set_regs(16'hFFFE, 16'h0010); run_op(2'b11, 16'h0, 16'h0);
        check("fault_pop_sp", sp_r, 16'hFFFE);
        set_regs(16'h0000, 16'h0010); run_op(2'b00, 16'h0, 16'h2222);
        set_regs(16'hFFFF, 16'h0010); run_op(2'b01, 16'h0, 16'h0);
        set_regs(16'h0002, 16'h0010); run_op(2'b10, 16'hCAFE, 16'h0);
        check("edge_push_sp", sp_r, 16'h0000);
        set_regs(16'hFFFD, 16'h0010); run_op(2'b11, 16'h0, 16'h0);
        check("edge_pop_sp", sp_r, 16'hFFFF);

        // Start held high across a PUSH: second op only after DONE
        set_regs(16'h0400, 16'h0000);
        @(negedge Clock);
        Start = 1'b1; Op = 2'b10; PushData = 16'h1111;
        @(posedge Clock); #1;
        PushData = 16'h2222;
        for (int c = 1; c <= 7; c++) begin
            check("b2b_busy", Busy, bb_busy[c-1]);
            check("b2b_done", Done, bb_done[c-1]);
            if (c == 5) Start = 1'b0;
            if (c < 7) begin @(posedge Clock); #1; end
        end
        @(posedge Clock); #1;
        ref_push(16'h1111);
        ref_push(16'h2222);
        check("b2b_sp", sp_r, 16'h03FC);
        check("b2b_mem", {mem[16'h0400], mem[16'h03FF], mem[16'h03FE], mem[16'h03FD]}, 32'h11112222);

        // Reset during WL of a PUSH
        set_regs(16'h0300, 16'h0050);
        @(negedge Clock);
        Start = 1'b1; Op = 2'b10; PushData = 16'hA55A;
        @(posedge Clock); #1;
        Start = 1'b0;
        @(posedge Clock); #1;
        check("wl_strobe", {Mem_CS, Mem_WR, Mem_WrData}, {1'b1, 1'b1, 8'h5A});
        #2 Reset = 1'b0;
        #1;
        check("midrst_out", {ARF_RegSel, ARF_FunSel, Mem_CS, Mem_WR, Mem_WrData, Busy, Done, Fault}, 0);
        check("midrst_data", {PopData, LoadData}, 0);
        ref_mem[16'h0300] = 8'hA5;
        ref_sp   = 16'h02FF;
        ref_popv = 16'h0000;
        @(negedge Clock);
        Reset = 1'b1;
        check("midrst_sp", sp_r, 16'h02FF);
        check("midrst_nowl", mem[16'h02FF], ref_rd(16'h02FF));
        run_op(2'b10, 16'h0F0F, 16'h0);
        run_op(2'b11, 16'h0, 16'h0);
        check("midrst_pop", PopData, 16'h0F0F);

        // Randomized ops against the reference model
        for (int n = 0; n < 40; n++) begin
            int sel;
            sel = $urandom_range(0, 7);
            if (sel == 0)
                set_regs(bnd[$urandom_range(0, 7)], 16'($urandom));
            else if (sel == 1)
                set_regs(16'($urandom), 16'($urandom));
            run_op(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
